apb_bridge: RTL and testbench
=============================

APB_BRIDGE -- requirements
Module: apb_bridge

Interface
REQ-001 Parameter NUM_SLV, default 3: number of APB completers, range 1..16.
REQ-002 Parameter ADDR_W, default 12: paddr width; the completer index is paddr[ADDR_W-1:ADDR_W-4].
REQ-003 Parameter DATA_W, default 32: data bus width, a multiple of 8.
REQ-004 Parameter TIMEOUT_CYC, default 255: maximum ACCESS wait cycles before abort.
REQ-005 pclk  in  1  single clock; all logic rises on posedge.
REQ-006 preset  in  1  reset, synchronous and active-high.
REQ-007 req_valid  in  1  CPU request pending.
REQ-008 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  target address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_strb  in  DATA_W/8  byte strobes for writes.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-015 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-016 psel  out  NUM_SLV  one-hot completer select.
REQ-017 penable, pwrite  out  1 each  APB phase and direction.
REQ-018 paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8.
REQ-019 pready, pslverr  in  NUM_SLV each  per-completer ready and error.
REQ-020 prdata  in  NUM_SLV*DATA_W  packed; completer i occupies slice [i*DATA_W +: DATA_W].

Function
REQ-021 FSM states are IDLE, SETUP, ACCESS and DECERR; all APB outputs are registered.
REQ-022 req_ready = (IDLE) or (ACCESS and selected pready and not timeout abort); it is combinational.
REQ-023 Accept with index < NUM_SLV: latch addr, write, wdata and strb; go to SETUP next cycle with psel[idx]=1, penable=0.
REQ-024 Accept with index >= NUM_SLV: go to DECERR and drive no psel; the next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE.
REQ-025 SETUP -> ACCESS unconditionally; in ACCESS penable=1 and paddr/pwrite/pwdata/psel stay stable.
REQ-026 In ACCESS, only the selected completer's pready and pslverr are sampled; others are ignored.
REQ-027 On ACCESS with pready=1: the next cycle gives rsp_valid=1, rsp_err=pslverr[idx], rsp_rdata=prdata slice for reads and 0 for writes.
REQ-028 On ACCESS with pready=1 and req_valid=1: accept back-to-back and go directly to SETUP (or DECERR); otherwise go to IDLE.
REQ-029 Read pstrb is driven as all-zero.
REQ-030 Each transfer is 2 cycles plus wait states; rsp_valid follows the completing edge by 1 cycle.
REQ-031 rsp_valid is high for exactly one cycle per accepted request; the next response follows in order.

Reset
REQ-032 With preset high at posedge: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout counter=0.
REQ-033 Reset mid-transfer aborts the transfer silently with no rsp_valid; req_ready is 0 while preset is high.

Configuration
REQ-034 Macro APB_TIMEOUT_EN defined: an 8+ bit counter clears on entering ACCESS and increments each ACCESS cycle without pready; at count==TIMEOUT_CYC the bridge drops psel/penable, goes to IDLE and pulses rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-035 If pready and the timeout coincide, pready wins and the transfer completes normally.
REQ-036 Macro undefined: no counter logic exists; ACCESS waits indefinitely and TIMEOUT_CYC is unused.

Structure
REQ-037 Package apb_pkg holds the state enum (apb_state_t), the completer-index width constant, and the default parameter constants.
REQ-038 Sub-module apb_addr_decode: combinational, maps the address to a one-hot select plus a decode-error flag; instantiated once.

Verification
REQ-039 Read of addr 0x104 (NUM_SLV=3), completer 1 ready immediately, prdata1=0xDEADBEEF -> psel=3'b010 for 2 cycles; rsp_valid 1 cycle later with rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-040 Write of addr 0x010, data 0x12345678, strb 4'b0011, completer 0 with 3 wait states -> penable high for 4 cycles; pwdata and pstrb stable throughout; rsp_err=0.
REQ-041 Access to addr 0x300 (index 3 >= NUM_SLV) -> psel stays 0; rsp_valid with rsp_err=1 two cycles after accept.
REQ-042 Two back-to-back requests (0x000 read, then 0x200 write) -> SETUP follows ACCESS with no IDLE cycle; two rsp_valid pulses in order.
REQ-043 With APB_TIMEOUT_EN and TIMEOUT_CYC=4, pready held 0 -> abort after 4 ACCESS cycles; rsp_err=1; then IDLE.
REQ-044 Completer 2 returns pslverr=1 with pready -> rsp_err=1; assert preset in ACCESS -> all outputs 0 next cycle and no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default configuration for the APB bridge.
package apb_pkg;

  localparam int unsigned IDX_W           = 4;
  localparam int unsigned NUM_SLV_DEF     = 3;
  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DECERR
  } apb_state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the completer-index field of an address to a one-hot select, or flags
// a decode error when the index names a completer that does not exist.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = NUM_SLV_DEF
) (
  input  logic [IDX_W-1:0]   addr_idx_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               dec_err_o
);

  always_comb begin
    sel_o     = '0;
    dec_err_o = 1'b1;
    if (32'(addr_idx_i) < NUM_SLV) begin
      sel_o     = NUM_SLV'(1) << addr_idx_i;
      dec_err_o = 1'b0;
    end
  end

endmodule

// File: rtl/apb_bridge.sv
// CPU request/response to APB requester bridge for NUM_SLV completers.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
module apb_bridge
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV     = NUM_SLV_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_t          state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                req_ready_c;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_err;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TMO_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT_CYC has no effect without the timeout counter.
  if (TIMEOUT_CYC == 0) begin : g_no_timeout
  end
`endif

  apb_addr_decode #(
    .NUM_SLV (NUM_SLV)
  ) u_decode (
    .addr_idx_i (req_addr[ADDR_W-1 -: IDX_W]),
    .sel_o      (dec_sel),
    .dec_err_o  (dec_err)
  );

  // psel_q is one-hot and stable in ACCESS, so it masks out unselected completers.
  assign sel_ready = |(pready & psel_q);
  assign sel_err   = |(pslverr & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready_c = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      ST_IDLE: req_ready_c = 1'b1;
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          req_ready_c = 1'b1;
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_DECERR: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (preset) req_ready_c = 1'b0;

    // Acceptance overrides the IDLE return so back-to-back requests skip IDLE.
    if (req_ready_c && req_valid) begin
      paddr_d   = req_addr;
      pwrite_d  = req_write;
      pwdata_d  = req_wdata;
      pstrb_d   = req_write ? req_strb : '0;
      penable_d = 1'b0;
      if (dec_err) begin
        state_d = ST_DECERR;
        psel_d  = '0;
      end else begin
        state_d = ST_SETUP;
        psel_d  = dec_sel;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Scoreboard bench for apb_bridge: directed cases then randomized traffic,
// with reactive completers and monitors comparing against a transaction model.
module tb_apb_bridge;

  localparam int unsigned NUM_SLV = 3;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned TMO     = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif

  logic                      pclk;
  logic                      preset;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [STRB_W-1:0]         req_strb;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [STRB_W-1:0]         pstrb;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;
  logic [NUM_SLV*DATA_W-1:0] prdata;

  apb_bridge #(
    .NUM_SLV     (NUM_SLV),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  typedef struct {
    logic [NUM_SLV-1:0] psel;
    logic [ADDR_W-1:0]  addr;
    logic               wr;
    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  strb;
    int                 len;
  } apb_exp_t;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                cyc;
  } rsp_exp_t;

  typedef struct {
    int                w;
    logic              e;
    logic [DATA_W-1:0] d;
  } plan_t;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];
  plan_t    plan_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Completers: noise on every lane; the addressed one follows its planned wait count.
  plan_t cp;
  bit    c_act = 1'b0;
  int    c_k   = 0;
  always @(negedge pclk) begin
    int ci;
    pready  = 3'($urandom);
    pslverr = 3'($urandom);
    for (int i = 0; i < NUM_SLV; i++) prdata[i*DATA_W +: DATA_W] = $urandom;
    ci = 0;
    for (int i = 0; i < NUM_SLV; i++) if (psel[i]) ci = i;
    if (preset) c_act = 1'b0;
    else if (psel != '0 && !penable) begin
      if (plan_q.size() > 0) begin
        cp    = plan_q.pop_front();
        c_act = 1'b1;
        c_k   = 0;
      end
    end else if (penable && c_act) begin
      pready[ci]  = (c_k == cp.w);
      pslverr[ci] = cp.e;
      prdata[ci*DATA_W +: DATA_W] = cp.d;
      if (c_k == cp.w) c_act = 1'b0;
      c_k++;
    end
  end

  // APB-side monitor: setup contents, ACCESS length and stability.
  apb_exp_t cur;
  bit       in_acc    = 1'b0;
  int       acc_len   = 0;
  bit       stable_ok = 1'b1;
  always @(negedge pclk) begin
    if (preset) in_acc = 1'b0;
    else begin
      if (in_acc && !penable) begin
        check("apb_access_len", 64'(acc_len), 64'(cur.len));
        check("apb_access_stable", 64'(stable_ok), 64'(1));
        in_acc = 1'b0;
      end
      if (psel != '0 && !penable) begin
        if (apb_q.size() == 0) check("apb_extra_setup", 64'(psel), 64'(0));
        else begin
          cur = apb_q.pop_front();
          check("apb_psel", 64'(psel), 64'(cur.psel));
          check("apb_paddr", 64'(paddr), 64'(cur.addr));
          check("apb_pwrite", 64'(pwrite), 64'(cur.wr));
          check("apb_pwdata", 64'(pwdata), 64'(cur.wdata));
          check("apb_pstrb", 64'(pstrb), 64'(cur.strb));
          acc_len   = 0;
          stable_ok = 1'b1;
        end
      end else if (penable) begin
        in_acc = 1'b1;
        acc_len++;
        if (psel !== cur.psel || paddr !== cur.addr || pwrite !== cur.wr ||
            pwdata !== cur.wdata || pstrb !== cur.strb) stable_ok = 1'b0;
      end
    end
  end

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge pclk) begin
    rsp_exp_t r;
    if (!preset && rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) check("rsp_extra_pulse", 64'(rsp_valid), 64'(0));
      else begin
        r = rsp_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(r.err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        check("rsp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
  end

  // Issues one request and records what the model says must follow.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                      input logic [STRB_W-1:0] st, input int w, input logic e,
                      input logic [DATA_W-1:0] d, output int acc_cyc);
    int       waitc = 0;
    int       idx;
    int       len;
    bit       tmo;
    apb_exp_t a;
    rsp_exp_t r;
    plan_t    p;
    @(negedge pclk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = st;
    #1;
    while (!req_ready && waitc < 100) begin
      @(negedge pclk);
      #1;
      waitc++;
    end
    acc_cyc = cyc;
    if (!req_ready) begin
      check("req_accept_timeout", 64'(req_ready), 64'(1));
      req_valid = 1'b0;
      return;
    end
    idx = int'(addr) >> (ADDR_W - 4);
    if (idx >= NUM_SLV) begin
      r.err   = 1'b1;
      r.rdata = '0;
      r.cyc   = cyc + 2;
      rsp_q.push_back(r);
    end else begin
      tmo     = TOEN && (w >= TMO);
      len     = tmo ? TMO : w + 1;
      a.psel  = 3'(1 << idx);
      a.addr  = addr;
      a.wr    = wr;
      a.wdata = wd;
      a.strb  = wr ? st : '0;
      a.len   = len;
      apb_q.push_back(a);
      p.w = w;
      p.e = e;
      p.d = d;
      plan_q.push_back(p);
      r.err   = tmo ? 1'b1 : e;
      r.rdata = (tmo || wr) ? '0 : d;
      r.cyc   = cyc + 2 + len;
      rsp_q.push_back(r);
    end
    @(posedge pclk);
  endtask

  task automatic idle(input int n);
    @(negedge pclk);
    req_valid = 1'b0;
    repeat (n - 1) @(negedge pclk);
  endtask

  task automatic drain();
    int waitc = 0;
    @(negedge pclk);
    req_valid = 1'b0;
    while ((rsp_q.size() != 0 || in_acc) && waitc < 200) begin
      @(negedge pclk);
      waitc++;
    end
    check("drain_rsp_q", 64'(rsp_q.size()), 64'(0));
    check("drain_apb_q", 64'(apb_q.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_psel"}, 64'(psel), 64'(0));
    check({tag, "_penable"}, 64'(penable), 64'(0));
    check({tag, "_pwrite"}, 64'(pwrite), 64'(0));
    check({tag, "_paddr"}, 64'(paddr), 64'(0));
    check({tag, "_pwdata"}, 64'(pwdata), 64'(0));
    check({tag, "_pstrb"}, 64'(pstrb), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, waitc;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    repeat (3) @(negedge pclk);
    #1;
    check_all_zero("reset");
    preset = 1'b0;

    send(1'b0, 12'h104, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, c1);
    idle(2);
    send(1'b1, 12'h010, 32'h12345678, 4'b0011, 3, 1'b0, 32'hCAFE0000, c1);
    idle(1);
    send(1'b0, 12'h300, 32'h0, 4'h0, 0, 1'b0, 32'h0, c1);
    idle(3);
    send(1'b0, 12'h000, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_0001, c1);
    send(1'b1, 12'h200, 32'h0BAD_F00D, 4'hF, 0, 1'b0, 32'h0, c2);
    check("b2b_accept_cycle", 64'(c2), 64'(c1 + 3));
    idle(1);
    send(1'b0, 12'h2A0, 32'h0, 4'h0, 1, 1'b1, 32'h1357_9BDF, c1);
    idle(1);
`ifdef APB_TIMEOUT_EN
    send(1'b0, 12'h180, 32'h0, 4'h0, TMO + 2, 1'b0, 32'h2468_ACE0, c1);
    idle(1);
    send(1'b1, 12'h080, 32'h7777_7777, 4'hF, TMO - 1, 1'b0, 32'h0, c1);
    idle(1);
`endif
    drain();

    // Reset during ACCESS: transfer vanishes without a response.
    send(1'b0, 12'h2F0, 32'h0, 4'h0, 3, 1'b0, 32'h5555_AAAA, c1);
    @(negedge pclk);
    req_valid = 1'b0;
    waitc = 0;
    while (!penable && waitc < 10) begin
      @(negedge pclk);
      waitc++;
    end
    check("rst_reach_access", 64'(penable), 64'(1));
    preset = 1'b1;
    rsp_q.delete();
    plan_q.delete();
    @(negedge pclk);
    #1;
    check_all_zero("midrst");
    preset = 1'b0;
    idle(3);

    for (int t = 0; t < 150; t++) begin
      wr   = 1'($urandom);
      addr = {4'($urandom_range(0, 3)), 8'($urandom)};
      send(wr, addr, $urandom, 4'($urandom), $urandom_range(0, TOEN ? 6 : 3),
           1'($urandom), $urandom, c1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
